shift_counter_gen: RTL

- Parametrised multi-mode shift-register counter; successor to the team's fixed 4-bit Johnson counter.
- Modes: ring (one-hot), Johnson (twisted ring) and maximal-length Fibonacci LFSR.
- Also provides: shift direction control, parallel load, illegal-state detection with self-correction, and a wrap pulse.
- Used as a phase/sequence generator and pseudo-random source in timing and test logic.

---
 rtl/shift_counter_pkg.sv | 43 ++++
 rtl/shift_counter_next.sv | 59 +++++
 rtl/shift_counter_gen.sv | 73 +++++++
 3 files changed

// File: rtl/shift_counter_pkg.sv
// shift_counter_pkg
//   Shared definitions for the multi-mode shift-register counter:
//   mode encodings, maximal-length LFSR tap masks and the value a
//   corrupted counter is forced to when it steps.
package shift_counter_pkg;

  localparam logic [1:0] MODE_RING    = 2'b00;
  localparam logic [1:0] MODE_JOHNSON = 2'b01;
  localparam logic [1:0] MODE_LFSR    = 2'b10;
  localparam logic [1:0] MODE_HOLD    = 2'b11;

  // Tap masks for the right-shifting Fibonacci form used by the counter:
  // the new MSB is the XOR of the masked bits. Bit i of the mask is the x^i
  // coefficient of a primitive polynomial of degree width (x^width implied).
  function automatic logic [15:0] lfsr_taps(input int width);
    logic [15:0] taps;
    case (width)
      3:       taps = 16'h0003;  // x^3+x+1
      4:       taps = 16'h0003;  // x^4+x+1
      5:       taps = 16'h0005;  // x^5+x^2+1
      6:       taps = 16'h0003;  // x^6+x+1
      7:       taps = 16'h0003;  // x^7+x+1
      8:       taps = 16'h001D;  // x^8+x^4+x^3+x^2+1
      9:       taps = 16'h0011;  // x^9+x^4+1
      10:      taps = 16'h0009;  // x^10+x^3+1
      11:      taps = 16'h0005;  // x^11+x^2+1
      12:      taps = 16'h0053;  // x^12+x^6+x^4+x+1
      13:      taps = 16'h001B;  // x^13+x^4+x^3+x+1
      14:      taps = 16'h0443;  // x^14+x^10+x^6+x+1
      15:      taps = 16'h0003;  // x^15+x+1
      16:      taps = 16'h100B;  // x^16+x^12+x^3+x+1
      default: taps = 16'h0003;
    endcase
    return taps;
  endfunction

  // Value (as its LSB; all upper bits are zero) a counter in an illegal state
  // is forced to on its next step.
  function automatic logic correction_value(input logic [1:0] mode);
    return (mode == MODE_RING) || (mode == MODE_LFSR);
  endfunction

endpackage

// File: rtl/shift_counter_next.sv
// shift_counter_next
//   Combinational successor and legality logic for the shift counter.
//   Ports:
//     q       current counter state
//     mode    00 ring, 01 Johnson, 10 LFSR, 11 hold
//     dir     0 shift toward bit 0, 1 toward MSB (ignored for LFSR)
//     nxt     successor of q in the given mode/direction
//     illegal q is not a legal state of the given mode
module shift_counter_next
  import shift_counter_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] q,
  input  logic [1:0]       mode,
  input  logic             dir,
  output logic [WIDTH-1:0] nxt,
  output logic             illegal
);

  localparam logic [15:0] TAPS16 = lfsr_taps(WIDTH);

  logic             fb;
  logic             one_hot;
  logic [WIDTH-2:0] edges;
  logic             johnson_ok;

  assign fb      = ^(q & TAPS16[WIDTH-1:0]);
  assign one_hot = (q != '0) && ((q & (q - 1'b1)) == '0);

  // A Johnson state is a single run of ones and a single run of zeros,
  // i.e. at most one adjacent-bit transition.
  assign edges      = q[WIDTH-1:1] ^ q[WIDTH-2:0];
  assign johnson_ok = (edges & (edges - 1'b1)) == '0;

  always_comb begin
    nxt     = q;
    illegal = 1'b0;
    case (mode)
      MODE_RING: begin
        nxt     = dir ? {q[WIDTH-2:0], q[WIDTH-1]} : {q[0], q[WIDTH-1:1]};
        illegal = !one_hot;
      end
      MODE_JOHNSON: begin
        nxt     = dir ? {q[WIDTH-2:0], ~q[WIDTH-1]} : {~q[0], q[WIDTH-1:1]};
        illegal = !johnson_ok;
      end
      MODE_LFSR: begin
        nxt     = {fb, q[WIDTH-1:1]};
        illegal = (q == '0);
      end
      default: begin
        nxt     = q;
        illegal = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/shift_counter_gen.sv
// shift_counter_gen
//   Multi-mode shift-register counter (ring / Johnson / maximal LFSR) used
//   as a phase sequencer and pseudo-random source.
//   Ports:
//     clk      clock, rising edge
//     reset    synchronous active-high reset
//     en       advance one step per cycle
//     mode     00 ring, 01 Johnson, 10 LFSR, 11 hold
//     dir      shift direction for ring/Johnson
//     load     parallel load strobe (beats en)
//     load_val value taken on load
//     q        registered counter state
//     illegal  combinational: q is not legal for the current mode
//     wrap     registered pulse: the last step landed back on the seed
module shift_counter_gen
  import shift_counter_pkg::*;
#(
  parameter int WIDTH       = 4,
  parameter int RESET_VALUE = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic [1:0]       mode,
  input  logic             dir,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] q,
  output logic             illegal,
  output logic             wrap
);

  localparam logic [WIDTH-1:0] RV = RESET_VALUE[WIDTH-1:0];

  logic [WIDTH-1:0] seed;
  logic [WIDTH-1:0] nxt;
  logic [WIDTH-1:0] corr;

  shift_counter_next #(.WIDTH(WIDTH)) u_next (
    .q       (q),
    .mode    (mode),
    .dir     (dir),
    .nxt     (nxt),
    .illegal (illegal)
  );

  assign corr = {{(WIDTH-1){1'b0}}, correction_value(mode)};

  always_ff @(posedge clk) begin
    if (reset) begin
      q    <= RV;
      seed <= RV;
      wrap <= 1'b0;
    end else if (load) begin
      q    <= load_val;
      seed <= load_val;
      wrap <= 1'b0;
    end else if (en && (mode != MODE_HOLD)) begin
      if (illegal) begin
        // The correction value restarts the sequence, so it becomes the seed.
        q    <= corr;
        seed <= corr;
        wrap <= 1'b0;
      end else begin
        q    <= nxt;
        wrap <= (nxt == seed);
      end
    end else begin
      wrap <= 1'b0;
    end
  end

endmodule
